// File: rtl/ad_frame_reader_pkg.sv
// ad_frame_reader_pkg: shared widths, frame constants and FSM encoding
// for the AD frame reader and its skid FIFO.
`timescale 1ns/1ps
package ad_frame_reader_pkg;

  // Cache geometry (must match the ping-pong AD cache).
  localparam int AD_DATA_NBIT     = 16;
  localparam int AD_CHE_DATA_SIZE = 8;

  // Default frame sync word and overrun counter width.
  localparam logic [15:0] AD_FRM_SYNC     = 16'hEB90;
  localparam int          AD_FRM_OVR_NBIT = 8;

  // Frame FSM: each non-idle state names the word currently presented.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_HDR  = 3'd2,
    ST_DATA = 3'd3,
    ST_CHK  = 3'd4
  } frm_state_e;

  // Saturating increment for the overrun counter.
  function automatic logic [AD_FRM_OVR_NBIT-1:0] ovr_sat_inc(
    input logic [AD_FRM_OVR_NBIT-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ad_skid_fifo.sv
// ad_skid_fifo: small synchronous FIFO catching cache read returns so the
// frame output can stall without losing in-flight samples. The head word is
// visible combinationally (register storage), occupancy is reported.
`timescale 1ns/1ps
module ad_skid_fifo #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage write; contents need no reset since occupancy gates the head.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= push_data;
  end

  // Pointer and occupancy update for push/pop.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push) wr_ptr_next = ptr_inc(wr_ptr_reg);
    if (pop)  rd_ptr_next = ptr_inc(rd_ptr_reg);
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Pointer/occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  assign head_data = mem[rd_ptr_reg];
  assign empty     = (count_reg == '0);
  assign count     = count_reg;

endmodule

// File: rtl/ad_frame_reader.sv
// ad_frame_reader: on each cache `switch`, drains one half-buffer through
// rd/rdata and emits SYNC, header {ovr_flag, frame_cnt}, NSAMP samples and
// (when AD_FRM_CHK_EN is defined) an XOR checksum, on a valid/ready stream.
// Optional feature macro: AD_FRM_CHK_EN.
`timescale 1ns/1ps
module ad_frame_reader
  import ad_frame_reader_pkg::*;
#(
  parameter int                      RD_LAT    = 1,
  parameter logic [AD_DATA_NBIT-1:0] SYNC_WORD = AD_FRM_SYNC[AD_DATA_NBIT-1:0],
  parameter int                      NSAMP     = AD_CHE_DATA_SIZE
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       switch,
  output logic                       rd,
  input  logic [AD_DATA_NBIT-1:0]    rdata,
  output logic [AD_DATA_NBIT-1:0]    out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_sof,
  output logic                       out_eof,
  output logic [AD_FRM_OVR_NBIT-1:0] ovr_cnt
);

  localparam int DEPTH  = RD_LAT + 2;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int SCNT_W = $clog2(NSAMP + 1);

  frm_state_e                  state_reg, state_next;
  logic [AD_DATA_NBIT-1:0]     word_reg, word_next;
  logic [AD_DATA_NBIT-2:0]     frame_cnt_reg, frame_cnt_next;
  logic                        ovr_flag_reg, ovr_flag_next;
  logic [AD_FRM_OVR_NBIT-1:0]  ovr_cnt_reg, ovr_cnt_next;
  logic [SCNT_W-1:0]           issued_reg, issued_next;
  logic [SCNT_W-1:0]           sent_reg, sent_next;
  logic [RD_LAT-1:0]           rd_dly_reg;
`ifdef AD_FRM_CHK_EN
  logic [AD_DATA_NBIT-1:0]     chk_reg, chk_next;
`endif

  logic [AD_DATA_NBIT-1:0] fifo_head;
  logic                    fifo_empty;
  logic [CNT_W-1:0]        fifo_count;
  logic                    accept;
  logic                    switch_busy;
  logic                    last_sample;
  int                      in_flight;

  ad_skid_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (AD_DATA_NBIT),
    .CNT_W (CNT_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_dly_reg[RD_LAT-1]),
    .push_data (rdata),
    .pop       (accept && (state_reg == ST_DATA)),
    .head_data (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Reads still in the cache pipeline hold a reserved skid slot.
  always_comb begin
    in_flight = $countones(rd_dly_reg);
  end

  // Prefetch as soon as the frame starts, never beyond the skid capacity.
  assign rd = (state_reg != ST_IDLE)
           && (issued_reg < SCNT_W'(NSAMP))
           && ((int'(fifo_count) + in_flight) < DEPTH);

  assign switch_busy = switch && (state_reg != ST_IDLE);
  assign last_sample = (sent_reg == SCNT_W'(NSAMP - 1));
  assign accept      = out_valid && out_ready;
  assign ovr_cnt     = ovr_cnt_reg;

  // Output decode: all sources are registers, so words hold while stalled.
  always_comb begin
    out_valid = 1'b0;
    out_data  = word_reg;
    out_sof   = 1'b0;
    out_eof   = 1'b0;
    case (state_reg)
      ST_SYNC: begin
        out_valid = 1'b1;
        out_sof   = 1'b1;
      end
      ST_HDR: out_valid = 1'b1;
      ST_DATA: begin
        out_valid = ~fifo_empty;
        out_data  = fifo_head;
`ifndef AD_FRM_CHK_EN
        out_eof   = last_sample & ~fifo_empty;
`endif
      end
`ifdef AD_FRM_CHK_EN
      ST_CHK: begin
        out_valid = 1'b1;
        out_eof   = 1'b1;
      end
`endif
      default: out_valid = 1'b0;
    endcase
  end

  // Frame sequencing, header/checksum assembly and overrun bookkeeping.
  always_comb begin
    state_next     = state_reg;
    word_next      = word_reg;
    frame_cnt_next = frame_cnt_reg;
    ovr_flag_next  = ovr_flag_reg;
    ovr_cnt_next   = ovr_cnt_reg;
    issued_next    = issued_reg;
    sent_next      = sent_reg;
`ifdef AD_FRM_CHK_EN
    chk_next       = chk_reg;
`endif
    if (switch_busy) begin
      ovr_flag_next = 1'b1;
      ovr_cnt_next  = ovr_sat_inc(ovr_cnt_reg);
    end
    if (rd) issued_next = issued_reg + 1'b1;
    case (state_reg)
      ST_IDLE: begin
        if (switch) begin
          state_next  = ST_SYNC;
          word_next   = SYNC_WORD;
          issued_next = '0;
          sent_next   = '0;
        end
      end
      ST_SYNC: begin
        // The flag is handed to the header as it is latched, so a switch
        // arriving while the header waits is reported in the next frame.
        if (accept) begin
          state_next    = ST_HDR;
          word_next     = {ovr_flag_reg, frame_cnt_reg};
          ovr_flag_next = switch_busy;
`ifdef AD_FRM_CHK_EN
          chk_next      = {ovr_flag_reg, frame_cnt_reg};
`endif
        end
      end
      ST_HDR: begin
        if (accept) state_next = ST_DATA;
      end
      ST_DATA: begin
        if (accept) begin
          sent_next = sent_reg + 1'b1;
`ifdef AD_FRM_CHK_EN
          chk_next  = chk_reg ^ fifo_head;
          if (last_sample) begin
            state_next = ST_CHK;
            word_next  = chk_reg ^ fifo_head;
          end
`else
          if (last_sample) begin
            state_next     = ST_IDLE;
            word_next      = '0;
            frame_cnt_next = frame_cnt_reg + 1'b1;
          end
`endif
        end
      end
`ifdef AD_FRM_CHK_EN
      ST_CHK: begin
        if (accept) begin
          state_next     = ST_IDLE;
          word_next      = '0;
          frame_cnt_next = frame_cnt_reg + 1'b1;
        end
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  // State registers; reset abandons any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      word_reg      <= '0;
      frame_cnt_reg <= '0;
      ovr_flag_reg  <= 1'b0;
      ovr_cnt_reg   <= '0;
      issued_reg    <= '0;
      sent_reg      <= '0;
`ifdef AD_FRM_CHK_EN
      chk_reg       <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      word_reg      <= word_next;
      frame_cnt_reg <= frame_cnt_next;
      ovr_flag_reg  <= ovr_flag_next;
      ovr_cnt_reg   <= ovr_cnt_next;
      issued_reg    <= issued_next;
      sent_reg      <= sent_next;
`ifdef AD_FRM_CHK_EN
      chk_reg       <= chk_next;
`endif
    end
  end

  // Read-strobe delay line; the last tap marks rdata as valid for the skid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_dly_reg <= '0;
    end else begin
      rd_dly_reg[0] <= rd;
      for (int i = 1; i < RD_LAT; i++) rd_dly_reg[i] <= rd_dly_reg[i-1];
    end
  end

endmodule

// File: tb/tb_ad_frame_reader.sv
// tb_ad_frame_reader: directed sequence of frames with random samples and
// ready patterns, checked against a word-level frame model and cache model.
`timescale 1ns/1ps
module tb_ad_frame_reader;
  import ad_frame_reader_pkg::*;

  localparam int W = AD_DATA_NBIT;
  localparam int N = AD_CHE_DATA_SIZE;
  localparam logic [W-1:0] SYNC = AD_FRM_SYNC[W-1:0];
`ifdef AD_FRM_CHK_EN
  localparam int LEN = N + 3;
`else
  localparam int LEN = N + 2;
`endif
  localparam int HMOD = 1 << (W - 1);

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic                       switch = 1'b0;
  logic                       out_ready = 1'b0;
  logic                       rd;
  logic [W-1:0]               rdata = '0;
  logic [W-1:0]               out_data;
  logic                       out_valid, out_sof, out_eof;
  logic [AD_FRM_OVR_NBIT-1:0] ovr_cnt;

  always #5 clk = ~clk;

  ad_frame_reader #(.RD_LAT(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .switch    (switch),
    .rd        (rd),
    .rdata     (rdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .ovr_cnt   (ovr_cnt)
  );

  // Cache model: half-buffer contents, 1-cycle read latency.
  logic [W-1:0] smem [N];
  int rd_total = 0;
  int rd_base  = 0;
  always @(posedge clk) begin
    if (rd) begin
      rdata    <= smem[(rd_total - rd_base) % N];
      rd_total <= rd_total + 1;
    end
  end

  int tests_run = 0;
  int fails     = 0;
  int frame_exp = 0;
  int ovr_exp   = 0;
  bit flag_exp  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input bit directed);
    for (int i = 0; i < N; i++) smem[i] = directed ? W'(i + 1) : W'($urandom);
    rd_base = rd_total;
  endtask

  // One frame: optional start pulse, ready pattern (0 high, 1 toggle,
  // 2 random), optional busy switch once in DATA, optional abort cycle.
  task automatic run_frame(input bit start, input int mode, input int busy_at,
                           input int abort_at, input string name);
    logic [W-1:0] exp_w, hdr, chk, p_data;
    bit p_stall, p_sof, p_eof, sent_busy, done;
    int widx, cyc;
    widx = 0; done = 0; p_stall = 0; sent_busy = 0;
    hdr = '0; chk = '0; p_data = '0; p_sof = 0; p_eof = 0; exp_w = '0;
    if (start) begin
      switch    = 1'b1;
      out_ready = (mode == 0);
      @(negedge clk);
      switch = 1'b0;
      check("sof_latency", {30'd0, out_valid, out_sof}, 32'd3);
      check("sync_word", out_data, SYNC);
    end
    for (cyc = 0; cyc < 300 && !done; cyc++) begin
      if (cyc == abort_at) break;
      switch = 1'b0;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 2 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (!sent_busy && busy_at >= 0 && cyc >= busy_at && widx >= 2 && widx <= N + 1) begin
        switch    = 1'b1;
        sent_busy = 1'b1;
        flag_exp  = 1'b1;
        ovr_exp   = (ovr_exp < 255) ? ovr_exp + 1 : 255;
      end
      if (p_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, p_data);
        check("hold_flags", {30'd0, out_sof, out_eof}, {30'd0, p_sof, p_eof});
      end
      if (out_valid && out_ready) begin
        if (widx == 0) exp_w = SYNC;
        else if (widx == 1) begin
          hdr      = {flag_exp, (W-1)'(frame_exp)};
          flag_exp = 1'b0;
          chk      = hdr;
          exp_w    = hdr;
        end else if (widx <= N + 1) begin
          exp_w = smem[widx - 2];
          chk   = chk ^ exp_w;
        end else exp_w = chk;
        check($sformatf("word%0d", widx), out_data, exp_w);
        check($sformatf("sof_eof%0d", widx), {30'd0, out_sof, out_eof},
              {30'd0, widx == 0, widx == LEN - 1});
        widx++;
        if (widx == LEN) done = 1;
      end
      p_stall = out_valid && !out_ready;
      p_data  = out_data;
      p_sof   = out_sof;
      p_eof   = out_eof;
      @(negedge clk);
    end
    switch = 1'b0;
    if (abort_at >= 0) return;
    check("frame_done", widx, LEN);
    check("rd_count", rd_total - rd_base, N);
    if (mode == 0) check("no_bubble_len", cyc, LEN);
    check("ovr_cnt", ovr_cnt, ovr_exp);
    frame_exp = (frame_exp + 1) % HMOD;
    $display("[TB] frame %s: %0d words, header %0h, ovr_cnt %0d", name, widx, hdr, ovr_cnt);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ctrl", {28'd0, rd, out_valid, out_sof, out_eof}, 0);
    check("rst_data", out_data, 0);
    check("rst_ovr", ovr_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);

    fill(1); run_frame(1, 0, -1, -1, "directed_1to8");
    fill(0); run_frame(1, 0, -1, -1, "second");
    fill(0); run_frame(1, 1, -1, -1, "ready_toggle");
    fill(0); run_frame(1, 2, -1, -1, "ready_random");
    fill(0); run_frame(1, 0, 4, -1, "busy_switch");
    fill(0); run_frame(1, 1, -1, -1, "ovr_header");
    fill(0); run_frame(1, 0, -1, -1, "ovr_cleared");

    // Frame stalled at SYNC while 300 busy switch pulses arrive.
    fill(0);
    switch    = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    switch = 1'b0;
    for (int k = 0; k < 300; k++) begin
      switch = 1'b1;
      @(negedge clk);
      switch = 1'b0;
      @(negedge clk);
      ovr_exp  = (ovr_exp < 255) ? ovr_exp + 1 : 255;
      flag_exp = 1'b1;
    end
    check("ovr_sat", ovr_cnt, ovr_exp);
    check("sat_still_sync", {30'd0, out_valid, out_sof}, 32'd3);
    run_frame(0, 2, -1, -1, "after_sat");

    // Reset in the middle of DATA.
    fill(0); run_frame(1, 0, -1, 5, "aborted");
    rst_n = 1'b0;
    #1;
    check("mid_rst_ctrl", {28'd0, rd, out_valid, out_sof, out_eof}, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_ovr", ovr_cnt, 0);
    frame_exp = 0; ovr_exp = 0; flag_exp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill(0); run_frame(1, 0, -1, -1, "after_reset");
    for (int k = 0; k < 3; k++) begin
      fill(0); run_frame(1, 2, -1, -1, "random_tail");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
